int_rf_mp: RTL

Multi-ported, banked integer register file for the expipe. It generalises the single-write-port RF to NUM_WR commit write ports and NUM_RD issue read ports, split into NUM_BANKS write banks. Each bank accepts one write per cycle. Same-bank write collisions are arbitrated round-robin and back-pressured through per-port ready signals. Optional write-to-read bypass and a saturating conflict counter are included for performance monitoring.

---
 rtl/int_rf_mp.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/int_rf_mp.sv
// int_rf_mp: banked integer register file with several write and read ports.
// Each write bank takes one write per cycle. Write ports that collide in the
// same bank are arbitrated round-robin per bank, and the ports that lose are
// back-pressured through comm_ready_o. Reads are combinational, with optional
// same-cycle forwarding of granted writes. A saturating counter records the
// number of cycles in which any write port stalled.
//
// Handshake (commit side): a write transfers on a rising edge where
// comm_valid_i[p] && comm_ready_o[p]. A requester that sees ready low must hold
// valid, index and data stable until ready is high. A port with valid low
// reports ready high. Writes to x0 are accepted at once and then dropped.
// Ready is a function only of the current inputs and the per-bank round-robin
// pointers. It never depends on itself, so there is no loop through valid.
module int_rf_mp #(
  parameter int XLEN        = 64,
  parameter int XREG_NUM    = 32,
  parameter int REG_IDX_LEN = $clog2(XREG_NUM),
  parameter int NUM_WR      = 2,
  parameter int NUM_RD      = 2,
  parameter int NUM_BANKS   = 2,
  parameter int BYPASS_EN   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_WR-1:0]             comm_valid_i,
  output logic [NUM_WR-1:0]             comm_ready_o,
  input  logic [NUM_WR*REG_IDX_LEN-1:0] comm_rd_idx_i,
  input  logic [NUM_WR*XLEN-1:0]        comm_rd_value_i,
  input  logic [NUM_RD*REG_IDX_LEN-1:0] issue_rs_idx_i,
  output logic [NUM_RD*XLEN-1:0]        issue_rs_value_o,
  output logic [CNT_W-1:0]              conflict_cnt_o
);

  // Round-robin pointer width. It is kept at least 1 bit so that a
  // single-port build still has a legal vector.
  localparam int RR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  logic [XLEN-1:0]        regs    [XREG_NUM];
  logic [RR_W-1:0]        rr      [NUM_BANKS];
  logic [RR_W-1:0]        rr_nxt  [NUM_BANKS];
  logic [REG_IDX_LEN-1:0] wr_idx  [NUM_WR];
  logic [XLEN-1:0]        wr_val  [NUM_WR];
  int                     wr_bank [NUM_WR];
  logic [REG_IDX_LEN-1:0] rs_idx  [NUM_RD];
  logic [NUM_WR-1:0]      req;
  logic [NUM_WR-1:0]      to_x0;
  logic [NUM_WR-1:0]      grant;
  logic                   stall;
  logic [CNT_W-1:0]       cnt_q;

  // Unpack the flat port buses into per-port views.
  for (genvar gp = 0; gp < NUM_WR; gp++) begin : g_wr_unpack
    assign wr_idx[gp] = comm_rd_idx_i[gp*REG_IDX_LEN +: REG_IDX_LEN];
    assign wr_val[gp] = comm_rd_value_i[gp*XLEN +: XLEN];
  end
  for (genvar gr = 0; gr < NUM_RD; gr++) begin : g_rd_unpack
    assign rs_idx[gr] = issue_rs_idx_i[gr*REG_IDX_LEN +: REG_IDX_LEN];
  end

  // Classify each write port: a write to x0 is a sink, and any other valid
  // write requests its bank. Requests are held off during reset so that
  // nothing is granted while the array is being cleared.
  always_comb begin
    req   = '0;
    to_x0 = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      to_x0[p]   = (wr_idx[p] == '0);
      wr_bank[p] = int'(wr_idx[p]) % NUM_BANKS;
      req[p]     = comm_valid_i[p] && !to_x0[p] && !rst_i;
    end
  end

  // Per-bank round-robin arbitration. The scan for each bank starts at
  // rr[bank]. The first requester found wins, and the pointer then advances
  // to the port just after the winner.
  always_comb begin
    grant = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      logic found;
      int   p;
      found     = 1'b0;
      p         = 0;
      rr_nxt[b] = rr[b];
      for (int k = 0; k < NUM_WR; k++) begin
        p = (int'(rr[b]) + k) % NUM_WR;
        if (!found && req[p] && (wr_bank[p] == b)) begin
          grant[p]  = 1'b1;
          found     = 1'b1;
          rr_nxt[b] = RR_W'((p + 1) % NUM_WR);
        end
      end
    end
  end

  assign comm_ready_o   = ~comm_valid_i | to_x0 | grant;
  assign stall          = |(comm_valid_i & ~comm_ready_o);
  assign conflict_cnt_o = cnt_q;

  // Read ports. x0 and reset return zero. Otherwise a granted write in the
  // current cycle to the same register is forwarded when bypass is enabled,
  // and the array content is returned in all other cases.
  always_comb begin
    issue_rs_value_o = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      logic [XLEN-1:0] val;
      val = regs[rs_idx[r]];
      if (BYPASS_EN != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (grant[p] && (wr_idx[p] == rs_idx[r])) val = wr_val[p];
        end
      end
      if (rs_idx[r] == '0 || rst_i) val = '0;
      issue_rs_value_o[r*XLEN +: XLEN] = val;
    end
  end

  // Commit granted writes into the array. A grant implies a nonzero index,
  // so x0 is never written. Only one write per bank is granted, so two
  // granted writes can never target the same register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < XREG_NUM; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (grant[p]) regs[wr_idx[p]] <= wr_val[p];
      end
    end
  end

  // Advance the per-bank round-robin pointers. Banks with no grant hold
  // their pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) rr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) rr[b] <= rr_nxt[b];
    end
  end

  // Count stall cycles, saturating at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
